reg_file_bank: RTL and testbench
================================

// Module: reg_file_bank
// PURPOSE
//   Architectural register file storage: 32 x 32-bit registers, one write port, two read ports.
//   Sits directly upstream of the 32:1 read-select muxes in the decode stage.
//   Exports the full register array for the read muxes.
//   Also provides two ready-selected read ports for the datapath.
//   Register ZERO_REG is hardwired to zero.
//   Optional same-cycle write->read bypass, so decode sees a value being written back this cycle.
// PARAMETERS
//   DATA_W    32   register width in bits
//   NUM_REGS  32   number of registers; fixed at 32 (5-bit addresses)
//   ZERO_REG  31   index of the read-as-zero / write-ignored register
//   BYPASS    1    1: read port returns wr_data when wr_en and addresses match; 0: no bypass
// PORTS
//   clk       in   1              single clock; all state updates on posedge
//   rst_n     in   1              asynchronous, active-low reset
//   wr_en     in   1              write strobe, sampled at posedge clk
//   wr_addr   in   5              destination register
//   wr_data   in   DATA_W         write data
//   rd_addr1  in   5              read port 1 address
//   rd_addr2  in   5              read port 2 address
//   rd_data1  out  DATA_W         read port 1 data (combinational)
//   rd_data2  out  DATA_W         read port 2 data (combinational)
//   regs_out  out  [31:0][DATA_W-1:0]  full register array, feeds the 32:1 read muxes
// BEHAVIOUR
//   - Reset: rst_n low asynchronously clears every register to 0.
//     regs_out, rd_data1 and rd_data2 read 0 while rst_n is low.
//     wr_en is ignored while rst_n is low.
//   - Reset deassertion mid-operation: the first posedge with rst_n high may write. No writes are lost or replayed.
//   - Write: at posedge clk with rst_n high and wr_en high, reg[wr_addr] <= wr_data.
//     Only one register changes per cycle.
//   - Write to ZERO_REG: silently dropped; reg[ZERO_REG] is always 0.
//   - wr_en low: no register changes, whatever is on wr_addr or wr_data (including X).
//   - Read: rd_dataN = reg[rd_addrN], combinational, 0-cycle latency from the address.
//   - Read of ZERO_REG: always returns 0, including when it is bypass-matched.
//   - Bypass (BYPASS=1): if wr_en && wr_addr==rd_addrN && rd_addrN!=ZERO_REG, then rd_dataN = wr_data in the same cycle.
//     Both ports may bypass simultaneously.
//   - Bypass with BYPASS=0: rd_dataN shows the old value until the posedge commits the write.
//   - regs_out is never bypassed: it reflects committed state only.
//   - Write and read of the same register in one cycle: without bypass, the read sees the old value; the new value is visible after the edge.
//   - Arithmetic: none. Widths are exact, with no extension or truncation.
// STRUCTURE
//   - Shared package (cpu_pkg):
//     - REG_ADDR_W = 5
//     - DATA_W = 32
//     - ZERO_REG = 31
//     - typedef logic [DATA_W-1:0] word_t
//     - typedef word_t [31:0] reg_array_t
//   - Sub-module write_decoder_5to32 (addr, en -> one-hot 32-bit write enable).
//     Its enable input is wr_en && (wr_addr != ZERO_REG).
//   - Storage: 32 DATA_W-wide async-reset flops, each gated by its one-hot enable bit.
//   - Read ports: indexed select on the storage array plus bypass compare; no further sub-modules.
// TESTING
//   1. Reset: hold rst_n=0 with wr_en=1, wr_addr=3, wr_data=32'hDEAD_BEEF for 3 clocks.
//      Required: all regs_out = 0 and rd_data1 = 0 (rd_addr1=3).
//   2. Write/read: write reg5 = 32'h1234_5678, then reg6 = 32'hFFFF_FFFF.
//      Required: on the next cycle, rd_addr1=5 gives 32'h1234_5678 and rd_addr2=6 gives 32'hFFFF_FFFF.
//      All other regs remain 0.
//   3. Zero register: wr_en=1, wr_addr=31, wr_data=32'hA5A5_A5A5.
//      Required: rd_data1 (rd_addr1=31) = 0 before and after the edge; regs_out[31] = 0.
//   4. Bypass: BYPASS=1, reg7 = 32'h0000_0001, then drive wr_en=1, wr_addr=7, wr_data=32'h0000_0002 with rd_addr1=rd_addr2=7.
//      Required: both read ports = 32'h2 in the same cycle; regs_out[7] = 32'h1 until the edge.
//      With BYPASS=0 the read ports show 32'h1 until the edge.
//   5. Async reset mid-stream: load regs 0..30 with their own index, then pulse rst_n low between clock edges.
//      Required: every register reads 0 immediately, without waiting for clk.
//      The next write after release (reg2 = 32'h99) is the only nonzero register.
//   6. wr_en low with X on wr_addr/wr_data for 4 cycles.
//      Required: regs_out is unchanged and contains no X.

Source files
------------

// File: rtl/reg_file_bank_pkg.sv
// Shared CPU types and constants for the register file.
// Address width, data width and the hardwired-zero register index.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int ZERO_REG = 31;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t [31:0] reg_array_t;
endpackage

// File: rtl/write_decoder_5to32.sv
// One-hot write-enable decoder for the register file.
// Produces all zeros when en is low, whatever addr holds.
module write_decoder_5to32
  import cpu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  en,
  output logic [31:0]           onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_file_bank.sv
// 32-entry register file: one write port, two combinational read ports.
// Optional write-to-read bypass; regs_out always shows committed state.
module reg_file_bank
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [4:0]             wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [4:0]             rd_addr1,
  input  logic [4:0]             rd_addr2,
  output logic [DATA_W-1:0]      rd_data1,
  output logic [DATA_W-1:0]      rd_data2,
  output logic [31:0][DATA_W-1:0] regs_out
);

  localparam logic [4:0] ZA = ZERO_REG[4:0];

  logic [31:0]             we;
  logic [31:0][DATA_W-1:0] regs;
  logic                    wr_ok;

  assign wr_ok = wr_en && (wr_addr != ZA);

  write_decoder_5to32 u_dec (
    .addr   (wr_addr),
    .en     (wr_ok),
    .onehot (we)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_ff
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= '0;
        else if (we[i]) q <= wr_data;
      end
      assign regs[i] = q;
    end
  end

  assign regs_out = regs;

  // Bypass is masked in reset so reads stay zero while rst_n is low.
  logic byp1, byp2, zero1, zero2;
  assign zero1 = (rd_addr1 == ZA);
  assign zero2 = (rd_addr2 == ZA);
  assign byp1  = (BYPASS != 0) && rst_n && wr_en
                 && (wr_addr == rd_addr1) && !zero1;
  assign byp2  = (BYPASS != 0) && rst_n && wr_en
                 && (wr_addr == rd_addr2) && !zero2;

  always_comb begin
    rd_data1 = regs[rd_addr1];
    unique case (1'b1)
      zero1:   rd_data1 = '0;
      byp1:    rd_data1 = wr_data;
      default: ;
    endcase
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    unique case (1'b1)
      zero2:   rd_data2 = '0;
      byp2:    rd_data2 = wr_data;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Scoreboard bench for reg_file_bank, bypass and no-bypass builds.
// Stimulus queues expected values; a monitor pops and compares on each sample.
module tb_reg_file_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic [31:0] nb_rd1, nb_rd2;
  logic [31:0][31:0] regs_out, nb_regs;

  reg_file_bank #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .regs_out(regs_out)
  );

  reg_file_bank #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nb_rd1), .rd_data2(nb_rd2), .regs_out(nb_regs)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  event        sample_ev;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];

  task automatic push(string name, int sel, int idx, logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.idx = idx; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic push_all_regs(string name, int sel);
    for (int i = 0; i < 32; i++) push(name, sel, i, model[i]);
  endtask

  task automatic sample();
    #1;
    ->sample_ev;
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       act = rd_data1;
          1:       act = rd_data2;
          2:       act = regs_out[e.idx];
          3:       act = nb_rd1;
          4:       act = nb_rd2;
          default: act = nb_regs[e.idx];
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s[%0d]: got %h, expected %h",
                   e.name, e.idx, act, e.exp);
        end
      end
    end
  end

  task automatic write(int a, logic [31:0] d);
    wr_en = 1'b1; wr_addr = a[4:0]; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a != 31) model[a] = d;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd3;
    wr_data = 32'hDEAD_BEEF; rd_addr1 = 5'd3; rd_addr2 = 5'd0;

    repeat (3) @(posedge clk);
    #1;
    push("rst_rd1", 0, 0, 32'h0);
    push("rst_nb_rd1", 3, 0, 32'h0);
    push_all_regs("rst_regs", 2);
    sample();
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;

    write(5, 32'h1234_5678);
    write(6, 32'hFFFF_FFFF);
    rd_addr1 = 5'd5; rd_addr2 = 5'd6;
    push("wr_rd1", 0, 0, 32'h1234_5678);
    push("wr_rd2", 1, 0, 32'hFFFF_FFFF);
    push("wr_nb_rd1", 3, 0, 32'h1234_5678);
    push("wr_nb_rd2", 4, 0, 32'hFFFF_FFFF);
    push_all_regs("wr_regs", 2);
    sample();
    checks++;
    if (rd_data1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wr_direct_rd1: got %h, expected %h",
               rd_data1, 32'h1234_5678);
    end

    rd_addr1 = 5'd31;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5_A5A5;
    push("z_pre_rd1", 0, 0, 32'h0);
    push("z_pre_nb_rd1", 3, 0, 32'h0);
    push("z_pre_reg31", 2, 31, 32'h0);
    sample();
    @(posedge clk); #1;
    push("z_post_rd1", 0, 0, 32'h0);
    push("z_post_reg31", 2, 31, 32'h0);
    push("z_post_nb_reg31", 5, 31, 32'h0);
    sample();
    wr_en = 1'b0;

    write(7, 32'h1);
    rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2;
    push("byp_rd1", 0, 0, 32'h2);
    push("byp_rd2", 1, 0, 32'h2);
    push("byp_reg7", 2, 7, 32'h1);
    push("nobyp_rd1", 3, 0, 32'h1);
    push("nobyp_rd2", 4, 0, 32'h1);
    push("nobyp_reg7", 5, 7, 32'h1);
    sample();
    checks++;
    if (rd_data2 !== 32'h2) begin
      errors++;
      $display("FAIL byp_direct_rd2: got %h, expected %h",
               rd_data2, 32'h2);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    model[7] = 32'h2;
    push("byp_post_rd1", 0, 0, 32'h2);
    push("byp_post_reg7", 2, 7, 32'h2);
    push("nobyp_post_rd2", 4, 0, 32'h2);
    sample();

    for (int i = 0; i < 31; i++) write(i, i);
    push_all_regs("load_regs", 2);
    sample();
    rd_addr1 = 5'd5; rd_addr2 = 5'd30;
    @(posedge clk); #3;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    push("arst_rd1", 0, 0, 32'h0);
    push("arst_rd2", 1, 0, 32'h0);
    push_all_regs("arst_regs", 2);
    push_all_regs("arst_nb_regs", 5);
    sample();
    rst_n = 1'b1;
    write(2, 32'h99);
    push_all_regs("post_rst_regs", 2);
    sample();
    checks++;
    if (regs_out[2] !== 32'h99) begin
      errors++;
      $display("FAIL post_rst_direct_reg2: got %h, expected %h",
               regs_out[2], 32'h99);
    end

    wr_en = 1'b0; wr_addr = 'x; wr_data = 'x;
    repeat (4) @(posedge clk);
    #1;
    push_all_regs("x_idle_regs", 2);
    push_all_regs("x_idle_nb_regs", 5);
    sample();
    wr_addr = 5'd0; wr_data = '0;

    sample();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
